// File: rtl/det_pkg.sv
// Shared types, sizes and address helper for the determinant elimination sequencer.
package det_pkg;

  localparam int MAX_DIM = 32;
  localparam int ADDR_W  = 10;
  localparam int SIZE_W  = 6;

  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_PIVOT  = 2'd1,
    OP_FACTOR = 2'd2,
    OP_UPDATE = 2'd3
  } op_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_PIVOT,
    S_ISSUE_FACTOR,
    S_ISSUE_UPDATE,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  function automatic logic [ADDR_W-1:0] rowcol2addr(input logic [SIZE_W-1:0] r,
                                                    input logic [SIZE_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(MAX_DIM) + ADDR_W'(c);
  endfunction

  function automatic seq_state_e op2state(input op_code_e op);
    case (op)
      OP_PIVOT:  return S_ISSUE_PIVOT;
      OP_FACTOR: return S_ISSUE_FACTOR;
      OP_UPDATE: return S_ISSUE_UPDATE;
      default:   return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/det_loop_idx.sv
// k/i/j nested loop counter for the elimination order. Outputs describe the
// position that follows the current one, so the caller can register it on advance.
module det_loop_idx
  import det_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              advance,
  input  logic [SIZE_W-1:0] n,
  output logic [SIZE_W-1:0] nxt_k,
  output logic [SIZE_W-1:0] nxt_i,
  output logic [SIZE_W-1:0] nxt_j,
  output op_code_e          nxt_op,
  output logic              nxt_last
);

  logic [SIZE_W-1:0] n_q;
  logic [SIZE_W-1:0] n_m1;
  logic [SIZE_W-1:0] k;
  logic [SIZE_W-1:0] i;
  logic [SIZE_W-1:0] j;
  op_code_e          op;

  assign n_m1 = n_q - 1'b1;

  always_comb begin
    nxt_k  = k;
    nxt_i  = i;
    nxt_j  = j;
    nxt_op = op;
    case (op)
      OP_PIVOT: begin
        nxt_op = OP_FACTOR;
        nxt_i  = k + 1'b1;
      end
      OP_FACTOR: begin
        nxt_op = OP_UPDATE;
        nxt_j  = k + 1'b1;
      end
      OP_UPDATE: begin
        if (j != n_m1) begin
          nxt_j = j + 1'b1;
        end else if (i != n_m1) begin
          nxt_i  = i + 1'b1;
          nxt_op = OP_FACTOR;
        end else begin
          nxt_k  = k + 1'b1;
          nxt_op = OP_PIVOT;
        end
      end
      default: ;
    endcase
    nxt_last = (nxt_op == OP_PIVOT) && (nxt_k == n_m1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q <= '0;
      k   <= '0;
      i   <= '0;
      j   <= '0;
      op  <= OP_NOP;
    end else if (init) begin
      n_q <= n;
      k   <= '0;
      i   <= '0;
      j   <= '0;
      op  <= OP_PIVOT;
    end else if (advance) begin
      k  <= nxt_k;
      i  <= nxt_i;
      j  <= nxt_j;
      op <= nxt_op;
    end
  end

endmodule

// File: rtl/det_elim_sequencer.sv
// Issues the PIVOT/FACTOR/UPDATE stream for Gaussian elimination, then drains and pulses done.
// Optional zero-pivot abort is enabled by defining DET_SEQ_PIVOT_ABORT_EN.
module det_elim_sequencer
  import det_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE_W-1:0] mxsize,
  output logic              busy,
  output logic              done,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [1:0]        op_code,
  output logic [ADDR_W-1:0] op_addr_a,
  output logic [ADDR_W-1:0] op_addr_b,
  output logic              op_last,
  input  logic              dp_idle,
  input  logic              pivot_zero,
  output logic              singular
);

  seq_state_e        state;
  logic [SIZE_W-1:0] n_start;
  logic              start_ok;
  logic              issuing;
  logic              handshake;
  logic              advance;
  logic              abort;
  logic              singular_q;
  logic [SIZE_W-1:0] nxt_k;
  logic [SIZE_W-1:0] nxt_i;
  logic [SIZE_W-1:0] nxt_j;
  op_code_e          nxt_op;
  logic              nxt_last;
  logic [ADDR_W-1:0] nxt_addr_a;
  logic [ADDR_W-1:0] nxt_addr_b;

`ifdef DET_SEQ_PIVOT_ABORT_EN
  assign abort    = pivot_zero;
  assign singular = singular_q;
`else
  logic unused_abort_sigs;
  assign abort             = 1'b0;
  assign singular          = 1'b0;
  assign unused_abort_sigs = pivot_zero ^ singular_q;
`endif

  assign n_start   = (mxsize > SIZE_W'(MAX_DIM)) ? SIZE_W'(MAX_DIM) : mxsize;
  assign start_ok  = start && (state == S_IDLE);
  assign issuing   = state inside {S_ISSUE_PIVOT, S_ISSUE_FACTOR, S_ISSUE_UPDATE};
  assign handshake = issuing && op_valid && op_ready;
  assign advance   = handshake && !op_last && !abort;

  det_loop_idx u_loop_idx (
    .clk      (clk),
    .reset    (reset),
    .init     (start_ok),
    .advance  (advance),
    .n        (n_start),
    .nxt_k    (nxt_k),
    .nxt_i    (nxt_i),
    .nxt_j    (nxt_j),
    .nxt_op   (nxt_op),
    .nxt_last (nxt_last)
  );

  always_comb begin
    nxt_addr_a = rowcol2addr(nxt_k, nxt_k);
    nxt_addr_b = rowcol2addr(nxt_k, nxt_k);
    case (nxt_op)
      OP_FACTOR: nxt_addr_a = rowcol2addr(nxt_i, nxt_k);
      OP_UPDATE: begin
        nxt_addr_a = rowcol2addr(nxt_i, nxt_j);
        nxt_addr_b = rowcol2addr(nxt_k, nxt_j);
      end
      default: ;
    endcase
  end

  // The first op is always PIVOT(0,0), so it is loaded directly on start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      op_valid   <= 1'b0;
      op_code    <= OP_NOP;
      op_addr_a  <= '0;
      op_addr_b  <= '0;
      op_last    <= 1'b0;
      singular_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            busy       <= 1'b1;
            singular_q <= 1'b0;
            if (n_start == '0) begin
              state <= S_DRAIN;
            end else begin
              state     <= S_ISSUE_PIVOT;
              op_valid  <= 1'b1;
              op_code   <= OP_PIVOT;
              op_addr_a <= '0;
              op_addr_b <= '0;
              op_last   <= (n_start == SIZE_W'(1));
            end
          end
        end
        S_ISSUE_PIVOT, S_ISSUE_FACTOR, S_ISSUE_UPDATE: begin
          if (abort || (handshake && op_last)) begin
            state     <= S_DRAIN;
            op_valid  <= 1'b0;
            op_code   <= OP_NOP;
            op_addr_a <= '0;
            op_addr_b <= '0;
            op_last   <= 1'b0;
            if (abort) singular_q <= 1'b1;
          end else if (handshake) begin
            state     <= op2state(nxt_op);
            op_code   <= nxt_op;
            op_addr_a <= nxt_addr_a;
            op_addr_b <= nxt_addr_b;
            op_last   <= nxt_last;
          end
        end
        S_DRAIN: begin
          if (abort) singular_q <= 1'b1;
          if (dp_idle) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_det_elim_sequencer.sv
// Self-checking bench for det_elim_sequencer: a queue of expected ops built from the
// elimination loop order is compared against every presented op.
module tb_det_elim_sequencer;
  import det_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [SIZE_W-1:0] mxsize;
  logic              busy;
  logic              done;
  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_code;
  logic [ADDR_W-1:0] op_addr_a;
  logic [ADDR_W-1:0] op_addr_b;
  logic              op_last;
  logic              dp_idle;
  logic              pivot_zero;
  logic              singular;

  int  checkCount  = 0;
  int  passCount   = 0;
  int  cycCount    = 0;
  int  hsCount     = 0;
  int  lastHsCycle = 0;
  bit  readyToggle = 1'b0;
  bit  monitorEn   = 1'b0;
  bit  prevHeld    = 1'b0;

  // Entry layout: {code[22:21], addr_a[20:11], addr_b[10:1], last[0]}
  logic [22:0] expQ[$];
  logic [22:0] hsLog[$];

  det_elim_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mxsize     (mxsize),
    .busy       (busy),
    .done       (done),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_addr_a  (op_addr_a),
    .op_addr_b  (op_addr_b),
    .op_last    (op_last),
    .dp_idle    (dp_idle),
    .pivot_zero (pivot_zero),
    .singular   (singular)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCount <= cycCount + 1;

  initial begin
    op_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (readyToggle) op_ready = ~op_ready;
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  function automatic int addrOf(input int r, input int c);
    return r * MAX_DIM + c;
  endfunction

  function automatic logic [22:0] opWord(input int code, input int a, input int b, input bit last);
    return {2'(code), 10'(a), 10'(b), last};
  endfunction

  task automatic buildModel(input int n);
    int nn;
    nn = (n > MAX_DIM) ? MAX_DIM : n;
    expQ.delete();
    for (int k = 0; k < nn; k++) begin
      expQ.push_back(opWord(1, addrOf(k, k), addrOf(k, k), k == nn - 1));
      for (int i = k + 1; i < nn; i++) begin
        expQ.push_back(opWord(2, addrOf(i, k), addrOf(k, k), 1'b0));
        for (int j = k + 1; j < nn; j++)
          expQ.push_back(opWord(3, addrOf(i, j), addrOf(k, j), 1'b0));
      end
    end
  endtask

  // Compare every presented op against the head of the expected queue.
  always @(negedge clk) begin
    logic [22:0] got;
    bit hs;
    bit held;
    if (monitorEn && !reset) begin
      got  = {op_code, op_addr_a, op_addr_b, op_last};
      hs   = op_valid && op_ready;
      held = op_valid && !op_ready;
`ifdef DET_SEQ_PIVOT_ABORT_EN
      if (pivot_zero) begin
        hs   = 1'b0;
        held = 1'b0;
      end
`endif
      if (prevHeld && !op_valid) checkOutput("valid_held_until_handshake", 32'(op_valid), 32'd1);
      if (op_valid) begin
        checkOutput("model_has_op", 32'(expQ.size() > 0), 32'(op_valid));
        if (expQ.size() > 0) checkOutput("op_fields", 32'(got), 32'(expQ[0]));
        if (hs) begin
          hsLog.push_back(got);
          hsCount++;
          if (op_last) lastHsCycle = cycCount;
          if (expQ.size() > 0) void'(expQ.pop_front());
        end
      end
      prevHeld = held;
    end else begin
      prevHeld = 1'b0;
    end
  end

  task automatic applyStimulus(input int n, input int expOps);
    buildModel(n);
    checkOutput($sformatf("model_len_n%0d", n), expQ.size(), expOps);
    hsLog.delete();
    hsCount = 0;
    mxsize  = SIZE_W'(n);
    start   = 1'b1;
    stepCycle();
    start   = 1'b0;
    mxsize  = 6'd5;
    checkOutput($sformatf("busy_after_start_n%0d", n), 32'(busy), 32'd1);
  endtask

  task automatic waitDone(input int budget, input string name, output int doneCyc);
    bit seen;
    seen    = 1'b0;
    doneCyc = -1;
    for (int c = 0; c < budget && !seen; c++) begin
      stepCycle();
      if (done) begin
        seen    = 1'b1;
        doneCyc = cycCount;
      end
    end
    checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({name, "_busy_low_in_done"}, 32'(busy), 32'd0);
      checkOutput({name, "_all_ops_issued"}, expQ.size(), 0);
      stepCycle();
      checkOutput({name, "_done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  task automatic waitHandshakes(input int count, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      if (hsCount >= count) found = 1'b1;
      else stepCycle();
    end
    checkOutput(name, 32'(found), 32'd1);
  endtask

  initial begin
    int d;
    bit found;
    logic [22:0] lastOp;

    reset = 1'b1; start = 1'b0; mxsize = '0; dp_idle = 1'b1; pivot_zero = 1'b0;
    repeat (2) stepCycle();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_op_valid", 32'(op_valid), 32'd0);
    checkOutput("rst_op_code", 32'(op_code), 32'd0);
    checkOutput("rst_op_addr_a", 32'(op_addr_a), 32'd0);
    checkOutput("rst_op_addr_b", 32'(op_addr_b), 32'd0);
    checkOutput("rst_op_last", 32'(op_last), 32'd0);
    checkOutput("rst_singular", 32'(singular), 32'd0);
    reset = 1'b0;
    monitorEn = 1'b1;
    stepCycle();

    $display("[TB] N=2, ready high");
    applyStimulus(2, 4);
    waitDone(50, "n2", d);
    checkOutput("n2_handshakes", hsLog.size(), 4);
    if (hsLog.size() == 4) begin
      checkOutput("n2_op0", 32'(hsLog[0]), 32'(opWord(1, 0, 0, 1'b0)));
      checkOutput("n2_op1", 32'(hsLog[1]), 32'(opWord(2, 32, 0, 1'b0)));
      checkOutput("n2_op2", 32'(hsLog[2]), 32'(opWord(3, 33, 1, 1'b0)));
      checkOutput("n2_op3", 32'(hsLog[3]), 32'(opWord(1, 33, 33, 1'b1)));
    end
    checkOutput("n2_done_latency", d - lastHsCycle, 2);

    $display("[TB] N=3, ready toggling, stray start while busy");
    readyToggle = 1'b1;
    applyStimulus(3, 11);
    mxsize = 6'd1;
    start  = 1'b1;
    stepCycle();
    start  = 1'b0;
    waitDone(200, "n3", d);
    readyToggle = 1'b0;
    op_ready    = 1'b1;
    checkOutput("n3_handshakes", hsCount, 11);
    if (hsLog.size() > 0) begin
      lastOp = hsLog[hsLog.size() - 1];
      checkOutput("n3_last_addr_a", 32'(lastOp[20:11]), 32'd66);
      checkOutput("n3_last_flag", 32'(lastOp[0]), 32'd1);
    end

    $display("[TB] N=0");
    applyStimulus(0, 0);
    waitDone(20, "n0", d);
    checkOutput("n0_handshakes", hsCount, 0);

    $display("[TB] N=40 clamps to 32");
    applyStimulus(40, 10944);
    waitDone(12000, "n40", d);
    checkOutput("n40_handshakes", hsCount, 10944);
    if (hsLog.size() > 0) begin
      lastOp = hsLog[hsLog.size() - 1];
      checkOutput("n40_last_addr_a", 32'(lastOp[20:11]), 32'd1023);
      checkOutput("n40_last_addr_b", 32'(lastOp[10:1]), 32'd1023);
    end

    $display("[TB] dp_idle held low after last op");
    dp_idle = 1'b0;
    applyStimulus(2, 4);
    waitHandshakes(4, 50, "idle_last_handshake_seen");
    for (int c = 0; c < 20; c++) begin
      checkOutput("idle_wait_busy_nodone", 32'({busy, done}), 32'd2);
      stepCycle();
    end
    dp_idle = 1'b1;
    stepCycle();
    checkOutput("idle_done_after_idle", 32'({busy, done}), 32'd1);
    mxsize = 6'd2;
    start  = 1'b1;
    stepCycle();
    start  = 1'b0;
    checkOutput("start_in_done_ignored", 32'({busy, done, op_valid}), 32'd0);
    stepCycle();
    checkOutput("start_in_done_still_idle", 32'(busy), 32'd0);

    $display("[TB] reset during UPDATE");
    applyStimulus(3, 11);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (op_valid && op_code == 2'd3) found = 1'b1;
      else stepCycle();
    end
    checkOutput("rst_update_seen", 32'(found), 32'd1);
    reset = 1'b1;
    stepCycle();
    checkOutput("midrst_op_valid", 32'(op_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    expQ.delete();
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("post_rst_quiet", 32'({busy, done, op_valid}), 32'd0);
    end
    applyStimulus(3, 11);
    waitDone(100, "rerun", d);
    checkOutput("rerun_handshakes", hsCount, 11);

    $display("[TB] pivot_zero after first PIVOT");
    applyStimulus(3, 11);
    waitHandshakes(1, 20, "abort_first_pivot_seen");
    pivot_zero = 1'b1;
    stepCycle();
    pivot_zero = 1'b0;
`ifdef DET_SEQ_PIVOT_ABORT_EN
    checkOutput("abort_valid_drop", 32'(op_valid), 32'd0);
    checkOutput("abort_singular", 32'(singular), 32'd1);
    expQ.delete();
    waitDone(20, "abort", d);
    checkOutput("abort_singular_held", 32'(singular), 32'd1);
    checkOutput("abort_handshakes", hsCount, 1);
    applyStimulus(1, 1);
    checkOutput("abort_singular_cleared", 32'(singular), 32'd0);
    waitDone(20, "after_abort", d);
`else
    waitDone(100, "noabort", d);
    checkOutput("noabort_handshakes", hsCount, 11);
    checkOutput("noabort_singular", 32'(singular), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
